// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared types and decode helpers for the RV32I ALU issue
//               controller: opcode constants, FSM state type, the
//               decoded-instruction record, and the combinational decode and
//               legality functions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] F7_ALT = 7'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        is_imm;
    } dec_t;

    // Field extraction. For I-type, funct7 is only forwarded for the shift
    // immediates (funct3 = 001/101, i.e. instr[13:12] = 01); everything else
    // sees 0, so an ADDI whose imm[10] is set can never look like SUB.
    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t d;
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.rd     = instr[11:7];
        d.funct3 = instr[14:12];
        d.is_imm = (instr[6:0] == OP_I);
        d.imm    = {{20{instr[31]}}, instr[31:20]};
        if (!d.is_imm || (instr[13:12] == 2'b01)) begin
            d.funct7 = instr[31:25];
        end else begin
            d.funct7 = 7'h00;
        end
        return d;
    endfunction

    function automatic logic instr_legal(input logic [31:0] instr, input int nregs);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ok;
        op = instr[6:0];
        f7 = instr[31:25];
        f3 = instr[14:12];
        ok = (int'(instr[19:15]) < nregs) && (int'(instr[11:7]) < nregs);
        case (op)
            OP_R: begin
                ok = ok && (int'(instr[24:20]) < nregs);
                if (f7 == F7_ALT) begin
                    ok = ok && ((f3 == 3'b000) || (f3 == 3'b101));
                end else if (f7 != 7'h00) begin
                    ok = 1'b0;
                end
            end
            OP_I: begin
                if (f3 == 3'b001) begin
                    ok = ok && (f7 == 7'h00);
                end else if (f3 == 3'b101) begin
                    ok = ok && ((f7 == 7'h00) || (f7 == F7_ALT));
                end
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : NREGS x XLEN register file. Two combinational read ports plus
//               a debug read port, one synchronous write port, x0 hardwired
//               to zero, asynchronous active-low clear.
// Ports       : clk, rst_n            - clock / async active-low clear
//               ra1/rd1, ra2/rd2      - operand read ports
//               we, wa, wd            - write port (writes to x0 dropped)
//               dbg_addr/dbg_data     - debug read port
//               Indices 0 or >= NREGS read as 0.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] mem [NREGS];

    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREGS);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && in_range(wa)) begin
            mem[wa[AW-1:0]] <= wd;
        end
    end

    assign rd1      = in_range(ra1)      ? mem[ra1[AW-1:0]]      : '0;
    assign rd2      = in_range(ra2)      ? mem[ra2[AW-1:0]]      : '0;
    assign dbg_data = in_range(dbg_addr) ? mem[dbg_addr[AW-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue/writeback controller for a combinational RV32I ALU.
//               Accepts one instruction per handshake, decodes R-type and
//               I-type ALU ops, drives operands for one EXEC cycle, captures
//               the result and writes it back to rd in WB.
// Ports       : instr_valid/instr_ready/instr - instruction handshake
//               alu_a/alu_b/alu_funct3/alu_funct7 - ALU operands (0 outside EXEC)
//               alu_result - combinational ALU result
//               done/done_rd/done_data - retirement pulse and writeback info
//               illegal - rejection pulse
//               dbg_addr/dbg_data - register-file debug read
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    input  logic [XLEN-1:0] alu_result,
    output logic            done,
    output logic [4:0]      done_rd,
    output logic [XLEN-1:0] done_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    state_t          state;
    dec_t            dec_q;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            accept;

    assign accept = instr_valid && instr_ready;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (dec_q.rs1),
        .rd1      (rs1_data),
        .ra2      (dec_q.rs2),
        .rd2      (rs2_data),
        .we       (state == WB),
        .wa       (dec_q.rd),
        .wd       (res_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Operands are only presented while the ALU result is being captured;
    // at every other time (including reset) the interface is held at 0.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_funct3 = '0;
        alu_funct7 = '0;
        if (state == EXEC) begin
            alu_a      = rs1_data;
            alu_b      = dec_q.is_imm ? dec_q.imm[XLEN-1:0] : rs2_data;
            alu_funct3 = dec_q.funct3;
            alu_funct7 = dec_q.funct7;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dec_q       <= '0;
            res_q       <= '0;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            done_rd     <= '0;
            done_data   <= '0;
            illegal     <= 1'b0;
        end else begin
            done      <= 1'b0;
            done_rd   <= '0;
            done_data <= '0;
            illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (instr_legal(instr, NREGS)) begin
                            dec_q       <= decode_instr(instr);
                            instr_ready <= 1'b0;
                            state       <= EXEC;
                        end else begin
                            // Rejected: stay ready, pulse illegal next cycle.
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res_q     <= alu_result;
                    done      <= 1'b1;
                    done_rd   <= dec_q.rd;
                    done_data <= alu_result;
                    state     <= WB;
                end
                WB: begin
                    // Register write happens at this edge in the regfile.
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. Provides a
//               behavioural RV32I ALU, applies a vector table, and checks
//               retirements against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic        done, illegal;
    logic [4:0]  done_rd;
    logic [31:0] done_data;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.XLEN(32), .NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_funct3  (alu_funct3),
        .alu_funct7  (alu_funct7),
        .alu_result  (alu_result),
        .done        (done),
        .done_rd     (done_rd),
        .done_data   (done_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural combinational RV32I ALU.
    always_comb begin
        alu_result = '0;
        case (alu_funct3)
            3'd0: alu_result = alu_funct7[5] ? (alu_a - alu_b) : (alu_a + alu_b);
            3'd1: alu_result = alu_a << alu_b[4:0];
            3'd2: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            3'd3: alu_result = {31'b0, alu_a < alu_b};
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_funct7[5] ? 32'($signed(alu_a) >>> alu_b[4:0])
                                             : (alu_a >> alu_b[4:0]);
            3'd6: alu_result = alu_a | alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
    end

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_t;

    localparam int NV = 12;
    vec_t        vecs [NV];
    sb_t         sbq [$];
    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done/illegal pulse must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && (done || illegal)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected done=%0b illegal=%0b rd=%0d data=%h",
                         done, illegal, done_rd, done_data);
            end else begin
                e = sbq.pop_front();
                chk("sb_exclusive", 32'(done & illegal), 32'd0);
                chk("sb_kind_illegal", 32'(illegal), 32'(e.ill));
                if (!e.ill) begin
                    chk("sb_done_rd", 32'(done_rd), 32'(e.rd));
                    chk("sb_done_data", done_data, e.data);
                end
            end
        end
    end

    task automatic issue(input vec_t v);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout ins=%h ready=%0b", v.ins, instr_ready);
            return;
        end
        instr       = v.ins;
        instr_valid = 1'b1;
        sbq.push_back('{ill: v.ill, rd: v.rd, data: v.data});
        @(negedge clk);                       // cycle 1
        instr_valid = 1'b0;
        instr       = '0;
        if (v.ill) begin
            chk("illegal_pulse", 32'(illegal), 32'd1);
            chk("illegal_no_done", 32'(done), 32'd0);
            chk("illegal_ready", 32'(instr_ready), 32'd1);
            @(negedge clk);
            chk("illegal_single", 32'(illegal), 32'd0);
        end else begin
            chk("exec_ready", 32'(instr_ready), 32'd0);
            chk("exec_a", alu_a, v.a);
            chk("exec_b", alu_b, v.b);
            chk("exec_f3", 32'(alu_funct3), 32'(v.f3));
            chk("exec_f7", 32'(alu_funct7), 32'(v.f7));
            @(negedge clk);                   // cycle 2: WB
            chk("wb_done", 32'(done), 32'd1);
            chk("wb_a_idle", alu_a, 32'd0);
            @(negedge clk);                   // cycle 3
            chk("post_ready", 32'(instr_ready), 32'd1);
            chk("post_done_low", 32'(done), 32'd0);
            if (v.rd != 5'd0) model[v.rd] = v.data;
            dbg_addr = v.rd;
            #1;
            chk("wb_regfile", dbg_data, model[v.rd]);
        end
    endtask

    task automatic check_all_regs(input string name);
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            chk(name, dbg_data, model[r]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v0;
        for (int r = 0; r < 32; r++) model[r] = '0;
        //            ins           ill   a             b             f3    f7     rd     data
        vecs[0]  = '{32'h00500093, 1'b0, 32'h0,        32'h5,        3'd0, 7'h00, 5'd1,  32'h5};
        vecs[1]  = '{32'hFFD00113, 1'b0, 32'h0,        32'hFFFFFFFD, 3'd0, 7'h00, 5'd2,  32'hFFFFFFFD};
        vecs[2]  = '{32'h402081B3, 1'b0, 32'h5,        32'hFFFFFFFD, 3'd0, 7'h20, 5'd3,  32'h8};
        vecs[3]  = '{32'h40115213, 1'b0, 32'hFFFFFFFD, 32'h401,      3'd5, 7'h20, 5'd4,  32'hFFFFFFFE};
        vecs[4]  = '{32'h40000293, 1'b0, 32'h0,        32'h400,      3'd0, 7'h00, 5'd5,  32'h400};
        vecs[5]  = '{32'h00112333, 1'b0, 32'hFFFFFFFD, 32'h5,        3'd2, 7'h00, 5'd6,  32'h1};
        vecs[6]  = '{32'h00002003, 1'b1, 32'h0,        32'h0,        3'd0, 7'h00, 5'd0,  32'h0};
        vecs[7]  = '{32'h40209233, 1'b1, 32'h0,        32'h0,        3'd0, 7'h00, 5'd0,  32'h0};
        vecs[8]  = '{32'h02109213, 1'b1, 32'h0,        32'h0,        3'd0, 7'h00, 5'd0,  32'h0};
        vecs[9]  = '{32'h00309393, 1'b0, 32'h5,        32'h3,        3'd1, 7'h00, 5'd7,  32'h28};
        vecs[10] = '{32'h00328433, 1'b0, 32'h400,      32'h8,        3'd0, 7'h00, 5'd8,  32'h408};
        vecs[11] = '{32'h00415493, 1'b0, 32'hFFFFFFFD, 32'h4,        3'd5, 7'h00, 5'd9,  32'h0FFFFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_done_data", done_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(instr_ready), 32'd1);
        check_all_regs("rst_regs");

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i]);
        end
        check_all_regs("final_regs");

        // Reset asserted during EXEC of ADDI x1,x0,5: in flight is discarded.
        @(negedge clk);
        instr       = 32'h00500093;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        chk("midrst_exec_b", alu_b, 32'h5);
        rst_n = 1'b0;
        #1;
        chk("midrst_b_zero", alu_b, 32'd0);
        chk("midrst_ready", 32'(instr_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        for (int r = 0; r < 32; r++) model[r] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all_regs("midrst_regs");

        // Write to x0: retires with data, register stays 0.
        v0 = '{32'h00700013, 1'b0, 32'h0, 32'h7, 3'd0, 7'h00, 5'd0, 32'h7};
        issue(v0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
